// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package pipe_pkg;
    localparam int FWD_REGFILE = 0;
    localparam int EXE = 0;
    localparam int MEM = 1;
    localparam int WB  = 2;

    // Widest register address a scoreboard entry can hold.
    localparam int REG_AW_MAX = 8;

    typedef struct packed {
        logic                  v;
        logic [REG_AW_MAX-1:0] rn;
        logic                  ld;
    } sb_entry_t;
endpackage

// File: rtl/pipe_hazard_unit_if.sv
// ID-stage request and hazard-control response bundle between the CPU and the hazard unit.
interface pipe_hazard_unit_if #(
    parameter int REG_AW = 5,
    parameter int FSEL_W = 2,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic              id_wreg;
    logic [REG_AW-1:0] id_rn;
    logic              id_m2reg;
    logic              branch_taken;
    logic              stall;
    logic              flush_if;
    logic [FSEL_W-1:0] fwd_a;
    logic [FSEL_W-1:0] fwd_b;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_rn, id_m2reg,
               branch_taken,
        input  stall, flush_if, fwd_a, fwd_b, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_rn, id_m2reg,
               branch_taken,
        output stall, flush_if, fwd_a, fwd_b, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Shift register of in-flight destinations, entry 0 = EXE through entry DEPTH-1 = WB.
module hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_v,
    input  logic [REG_AW-1:0]            in_rn,
    input  logic                         in_ld,
    output logic [DEPTH-1:0]             v,
    output logic [DEPTH-1:0][REG_AW-1:0] rn,
    output logic [DEPTH-1:0]             ld
);
    sb_entry_t ent [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) ent[k] <= '0;
        end else begin
            ent[0] <= '{v: in_v, rn: REG_AW_MAX'(in_rn), ld: in_ld};
            for (int k = 1; k < DEPTH; k++) ent[k] <= ent[k-1];
        end
    end

    logic [DEPTH-1:0] unused_hi;

    for (genvar k = 0; k < DEPTH; k++) begin : g_out
        assign v[k]  = ent[k].v;
        assign rn[k] = ent[k].rn[REG_AW-1:0];
        assign ld[k] = ent[k].ld;
        // Entry storage is sized for the widest address; upper bits are always zero.
        assign unused_hi[k] = ^ent[k].rn;
    end
endmodule

// File: rtl/pipe_hazard_unit.sv
// ID-stage stall, operand forward selects, IF flush and stall-cycle counter for the 5-stage pipe.
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int DEPTH   = 3,
    parameter int FORWARD = 1,
    parameter int CNT_W   = 16,
    localparam int FSEL_W = $clog2(DEPTH+1)
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_unit_if.slave hz
);
    typedef struct packed {
        logic              any;
        logic              lu;
        logic [FSEL_W-1:0] sel;
    } pick_t;

    logic [DEPTH-1:0]             sb_v;
    logic [DEPTH-1:0][REG_AW-1:0] sb_rn;
    logic [DEPTH-1:0]             sb_ld;
    logic                         stall_raw;
    logic                         chk_a, chk_b;
    pick_t                        pa, pb;
    logic [CNT_W-1:0]             cnt;

    hazard_scoreboard #(.REG_AW(REG_AW), .DEPTH(DEPTH)) u_sb (
        .clk   (clk),
        .rst   (rst),
        .in_v  (hz.id_valid & hz.id_wreg & ~hz.stall),
        .in_rn (hz.id_rn),
        .in_ld (hz.id_m2reg),
        .v     (sb_v),
        .rn    (sb_rn),
        .ld    (sb_ld)
    );

    // Youngest match wins; the WB entry is skipped because the regfile writes mid-cycle.
    function automatic pick_t pick(input logic [REG_AW-1:0] r, input logic chk);
        pick_t p;
        p = '{any: 1'b0, lu: 1'b0, sel: FSEL_W'(FWD_REGFILE)};
        if (chk) begin
            for (int k = 0; k < DEPTH-1; k++) begin
                if (!p.any && sb_v[k] && sb_rn[k] == r) begin
                    p.any = 1'b1;
                    if (k == EXE && sb_ld[k]) p.lu = 1'b1;
                    else                      p.sel = FSEL_W'(k+1);
                end
            end
        end
        return p;
    endfunction

    assign chk_a = hz.id_valid & hz.id_use_rs & (hz.id_rs != '0);
    assign chk_b = hz.id_valid & hz.id_use_rt & (hz.id_rt != '0);

    always_comb begin
        pa = pick(hz.id_rs, chk_a);
        pb = pick(hz.id_rt, chk_b);
        stall_raw = (FORWARD != 0) ? (pa.lu | pb.lu) : (pa.any | pb.any);
        hz.stall    = ~rst & stall_raw;
        hz.flush_if = ~rst & hz.branch_taken & ~stall_raw;
        hz.fwd_a    = FSEL_W'(FWD_REGFILE);
        hz.fwd_b    = FSEL_W'(FWD_REGFILE);
        if (FORWARD != 0 && !rst) begin
            hz.fwd_a = pa.sel;
            hz.fwd_b = pb.sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                         cnt <= '0;
        else if (hz.stall && cnt != '1)  cnt <= cnt + 1'b1;
    end

    assign hz.stall_count = cnt;

    logic unused_sb;
    assign unused_sb = ^{sb_ld[DEPTH-1:1], sb_v[DEPTH-1], sb_rn[DEPTH-1]};
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed checks of three hazard-unit configurations driven by one shared ID stream.
module tb_pipe_hazard_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 0, id_use_rs = 0, id_use_rt = 0, id_wreg = 0, id_m2reg = 0;
    logic       branch_taken = 0;
    logic [4:0] id_rs = 0, id_rt = 0, id_rn = 0;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    // f: forwarding, DEPTH=3. s: stall-only, DEPTH=3. c: stall-only, DEPTH=7, CNT_W=2.
    pipe_hazard_unit_if #(.REG_AW(5), .FSEL_W(2), .CNT_W(16)) if_f ();
    pipe_hazard_unit_if #(.REG_AW(5), .FSEL_W(2), .CNT_W(16)) if_s ();
    pipe_hazard_unit_if #(.REG_AW(5), .FSEL_W(3), .CNT_W(2))  if_c ();

    assign if_f.id_valid = id_valid;   assign if_s.id_valid = id_valid;   assign if_c.id_valid = id_valid;
    assign if_f.id_rs = id_rs;         assign if_s.id_rs = id_rs;         assign if_c.id_rs = id_rs;
    assign if_f.id_rt = id_rt;         assign if_s.id_rt = id_rt;         assign if_c.id_rt = id_rt;
    assign if_f.id_use_rs = id_use_rs; assign if_s.id_use_rs = id_use_rs; assign if_c.id_use_rs = id_use_rs;
    assign if_f.id_use_rt = id_use_rt; assign if_s.id_use_rt = id_use_rt; assign if_c.id_use_rt = id_use_rt;
    assign if_f.id_wreg = id_wreg;     assign if_s.id_wreg = id_wreg;     assign if_c.id_wreg = id_wreg;
    assign if_f.id_rn = id_rn;         assign if_s.id_rn = id_rn;         assign if_c.id_rn = id_rn;
    assign if_f.id_m2reg = id_m2reg;   assign if_s.id_m2reg = id_m2reg;   assign if_c.id_m2reg = id_m2reg;
    assign if_f.branch_taken = branch_taken;
    assign if_s.branch_taken = branch_taken;
    assign if_c.branch_taken = branch_taken;

    pipe_hazard_unit #(.REG_AW(5), .DEPTH(3), .FORWARD(1), .CNT_W(16)) u_f (.clk(clk), .rst(rst), .hz(if_f));
    pipe_hazard_unit #(.REG_AW(5), .DEPTH(3), .FORWARD(0), .CNT_W(16)) u_s (.clk(clk), .rst(rst), .hz(if_s));
    pipe_hazard_unit #(.REG_AW(5), .DEPTH(7), .FORWARD(0), .CNT_W(2))  u_c (.clk(clk), .rst(rst), .hz(if_c));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inst(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic urs, input logic urt, input logic w,
                            input logic [4:0] rn, input logic ld);
        id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_wreg = w; id_rn = rn; id_m2reg = ld;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        branch_taken = 1'b0;
        set_inst(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        branch_taken = 1'b1;
        set_inst(1, 3, 3, 1, 1, 1, 3, 1);
        tick();
        tick();
        total++; if (if_f.stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b exp=0", if_f.stall); end
        total++; if (if_f.flush_if !== 1'b0) begin bad++; $display("FAIL reset_flush got=%0b exp=0", if_f.flush_if); end
        total++; if (if_f.fwd_a !== 2'd0 || if_f.fwd_b !== 2'd0) begin bad++; $display("FAIL reset_fwd got=%0d/%0d exp=0/0", if_f.fwd_a, if_f.fwd_b); end
        total++; if (if_f.stall_count !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", if_f.stall_count); end
        total++; if (if_c.stall_count !== 2'd0) begin bad++; $display("FAIL reset_cnt_c got=%0d exp=0", if_c.stall_count); end
        do_reset();
        #1;
        total++; if (if_f.stall !== 1'b0 || if_s.stall !== 1'b0) begin bad++; $display("FAIL reset_empty got=%0b/%0b exp=0/0", if_f.stall, if_s.stall); end
    endtask

    task automatic test_fwd_exe();
        do_reset();
        set_inst(1, 1, 2, 1, 1, 1, 3, 0);
        tick();
        set_inst(1, 3, 1, 1, 1, 1, 4, 0);
        #1;
        total++; if (if_f.stall !== 1'b0) begin bad++; $display("FAIL fwd_exe_stall got=%0b exp=0", if_f.stall); end
        total++; if (if_f.fwd_a !== 2'd1) begin bad++; $display("FAIL fwd_exe_a got=%0d exp=1", if_f.fwd_a); end
        total++; if (if_f.fwd_b !== 2'd0) begin bad++; $display("FAIL fwd_exe_b got=%0d exp=0", if_f.fwd_b); end
    endtask

    task automatic test_wb_excluded();
        do_reset();
        set_inst(1, 1, 2, 1, 1, 1, 3, 0);
        tick();
        set_inst(1, 8, 9, 1, 1, 1, 6, 0);
        tick();
        set_inst(1, 8, 9, 1, 1, 1, 7, 0);
        tick();
        set_inst(1, 3, 3, 1, 1, 1, 5, 0);
        #1;
        total++; if (if_f.fwd_a !== 2'd0 || if_f.fwd_b !== 2'd0) begin bad++; $display("FAIL wb_excl_fwd got=%0d/%0d exp=0/0", if_f.fwd_a, if_f.fwd_b); end
        total++; if (if_f.stall !== 1'b0) begin bad++; $display("FAIL wb_excl_stall got=%0b exp=0", if_f.stall); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_inst(1, 1, 2, 1, 1, 1, 3, 1);
        tick();
        set_inst(1, 3, 3, 1, 1, 1, 5, 0);
        #1;
        total++; if (if_f.stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%0b exp=1", if_f.stall); end
        total++; if (if_f.fwd_a !== 2'd0 || if_f.fwd_b !== 2'd0) begin bad++; $display("FAIL lu_fwd_held got=%0d/%0d exp=0/0", if_f.fwd_a, if_f.fwd_b); end
        tick();
        total++; if (if_f.stall !== 1'b0) begin bad++; $display("FAIL lu_release got=%0b exp=0", if_f.stall); end
        total++; if (if_f.fwd_a !== 2'd2 || if_f.fwd_b !== 2'd2) begin bad++; $display("FAIL lu_fwd_mem got=%0d/%0d exp=2/2", if_f.fwd_a, if_f.fwd_b); end
        total++; if (if_f.stall_count !== 16'd1) begin bad++; $display("FAIL lu_cnt got=%0d exp=1", if_f.stall_count); end
        set_inst(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        total++; if (if_f.stall_count !== 16'd1) begin bad++; $display("FAIL lu_cnt_hold got=%0d exp=1", if_f.stall_count); end
    endtask

    task automatic test_stall_only();
        do_reset();
        set_inst(1, 1, 2, 1, 1, 1, 3, 0);
        tick();
        set_inst(1, 3, 1, 1, 1, 1, 4, 0);
        #1;
        total++; if (if_s.stall !== 1'b1) begin bad++; $display("FAIL so_stall1 got=%0b exp=1", if_s.stall); end
        tick();
        total++; if (if_s.stall !== 1'b1) begin bad++; $display("FAIL so_stall2 got=%0b exp=1", if_s.stall); end
        total++; if (if_s.fwd_a !== 2'd0) begin bad++; $display("FAIL so_fwd_mid got=%0d exp=0", if_s.fwd_a); end
        tick();
        total++; if (if_s.stall !== 1'b0) begin bad++; $display("FAIL so_release got=%0b exp=0", if_s.stall); end
        total++; if (if_s.fwd_a !== 2'd0) begin bad++; $display("FAIL so_fwd got=%0d exp=0", if_s.fwd_a); end
        total++; if (if_s.stall_count !== 16'd2) begin bad++; $display("FAIL so_cnt got=%0d exp=2", if_s.stall_count); end
    endtask

    task automatic test_r0_and_use();
        do_reset();
        set_inst(1, 1, 2, 1, 1, 1, 0, 0);
        tick();
        set_inst(1, 0, 0, 1, 1, 1, 5, 0);
        #1;
        total++; if (if_f.stall !== 1'b0 || if_f.fwd_a !== 2'd0) begin bad++; $display("FAIL r0_fwd got=%0b/%0d exp=0/0", if_f.stall, if_f.fwd_a); end
        total++; if (if_s.stall !== 1'b0) begin bad++; $display("FAIL r0_stall_only got=%0b exp=0", if_s.stall); end
        do_reset();
        set_inst(1, 1, 2, 1, 1, 1, 3, 1);
        tick();
        set_inst(1, 1, 3, 1, 0, 1, 5, 0);
        #1;
        total++; if (if_f.stall !== 1'b0 || if_f.fwd_b !== 2'd0) begin bad++; $display("FAIL no_use_rt got=%0b/%0d exp=0/0", if_f.stall, if_f.fwd_b); end
        total++; if (if_s.stall !== 1'b0) begin bad++; $display("FAIL no_use_rt_so got=%0b exp=0", if_s.stall); end
        set_inst(0, 3, 3, 1, 1, 1, 5, 0);
        #1;
        total++; if (if_f.stall !== 1'b0 || if_f.fwd_a !== 2'd0) begin bad++; $display("FAIL bubble got=%0b/%0d exp=0/0", if_f.stall, if_f.fwd_a); end
    endtask

    task automatic test_branch();
        do_reset();
        set_inst(1, 1, 2, 1, 1, 1, 3, 1);
        tick();
        set_inst(1, 3, 4, 1, 1, 0, 0, 0);
        branch_taken = 1'b1;
        #1;
        total++; if (if_f.stall !== 1'b1 || if_f.flush_if !== 1'b0) begin bad++; $display("FAIL br_stalled got=%0b/%0b exp=1/0", if_f.stall, if_f.flush_if); end
        tick();
        total++; if (if_f.stall !== 1'b0 || if_f.flush_if !== 1'b1) begin bad++; $display("FAIL br_flush got=%0b/%0b exp=0/1", if_f.stall, if_f.flush_if); end
        branch_taken = 1'b0;
    endtask

    task automatic test_saturate_reset();
        logic [1:0] exp_cnt;
        do_reset();
        set_inst(1, 1, 2, 1, 1, 1, 3, 0);
        tick();
        set_inst(1, 3, 1, 1, 1, 1, 5, 0);
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (if_c.stall !== 1'b1) begin bad++; $display("FAIL sat_stall%0d got=%0b exp=1", i, if_c.stall); end
            tick();
            exp_cnt = (i >= 2) ? 2'd3 : 2'(i + 1);
            total++; if (if_c.stall_count !== exp_cnt) begin bad++; $display("FAIL sat_cnt%0d got=%0d exp=%0d", i, if_c.stall_count, exp_cnt); end
        end
        total++; if (if_c.stall !== 1'b1) begin bad++; $display("FAIL sat_midstall got=%0b exp=1", if_c.stall); end
        rst = 1'b1;
        branch_taken = 1'b1;
        #1;
        total++; if (if_c.stall !== 1'b0 || if_c.flush_if !== 1'b0) begin bad++; $display("FAIL rst_force got=%0b/%0b exp=0/0", if_c.stall, if_c.flush_if); end
        tick();
        total++; if (if_c.stall_count !== 2'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", if_c.stall_count); end
        rst = 1'b0;
        branch_taken = 1'b0;
        #1;
        total++; if (if_c.stall !== 1'b0) begin bad++; $display("FAIL rst_empty got=%0b exp=0", if_c.stall); end
        tick();
        total++; if (if_c.stall !== 1'b0 || if_c.stall_count !== 2'd0) begin bad++; $display("FAIL rst_after got=%0b/%0d exp=0/0", if_c.stall, if_c.stall_count); end
    endtask

    initial begin
        test_reset();
        test_fwd_exe();
        test_wb_excluded();
        test_load_use();
        test_stall_only();
        test_r0_and_use();
        test_branch();
        test_saturate_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
